stack_memory: RTL and testbench

Parametrised successor to the SAP-2 memory unit. Holds the MAR and MDR registers and a byte-wide RAM of 2^ADDR_W entries. Adds a hardware return-address stack of STACK_DEPTH entries with full, empty and error flags, in place of the fixed two-byte call slot. Also adds two-cycle 16-bit word read and write sequences, with a busy handshake to the control unit.

---
 rtl/stack_memory.sv | 142 ++++++++++++++
 tb/tb_stack_memory.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/stack_memory.sv
// SAP-2 style memory unit: MAR/MDR, byte-wide RAM, a hardware return-address
// stack and two-cycle big-endian 16-bit word read/write sequences.
module stack_memory #(
  parameter  int ADDR_W      = 6,
  parameter  int STACK_DEPTH = 8,
  localparam int SP_W        = $clog2(STACK_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mar_loadh,
  input  logic        mar_loadl,
  input  logic        mdr_load,
  input  logic        ram_load,
  input  logic        ram_enh,
  input  logic        ram_enl,
  input  logic        word_rd,
  input  logic        word_wr,
  input  logic        call,
  input  logic        ret,
  input  logic [15:0] bus,
  output logic [15:0] out,
  output logic        busy,
  output logic        stack_full,
  output logic        stack_empty,
  output logic        stack_err
);

  typedef enum logic [1:0] {IDLE, RD2, WR2} state_t;

  typedef enum logic [2:0] {
    CMD_NONE, CMD_RET, CMD_CALL, CMD_WORD_RD, CMD_WORD_WR, CMD_ENH, CMD_ENL, CMD_LOAD
  } cmd_t;

  state_t state, state_next;
  cmd_t   cmd;

  logic [15:0]       mar;
  logic [15:0]       mdr;
  logic [SP_W-1:0]   sp;
  logic [ADDR_W-1:0] addr_q;

  logic [7:0]  ram   [2**ADDR_W];
  logic [15:0] stack [STACK_DEPTH];

  logic [ADDR_W-1:0] ram_idx;
  logic [ADDR_W-1:0] addr_nxt;
  logic [SP_W-2:0]   push_idx;
  logic [SP_W-2:0]   top_idx;
  logic              unused_mar;

  // Upper MAR bits only matter to a wider address map; RAM sees the low bits.
  assign ram_idx    = mar[ADDR_W-1:0];
  assign unused_mar = ^mar;
  assign addr_nxt   = addr_q + ADDR_W'(1);
  assign push_idx   = sp[SP_W-2:0];
  assign top_idx    = sp[SP_W-2:0] - (SP_W-1)'(1);

  assign out         = mdr;
  assign busy        = (state != IDLE);
  assign stack_full  = (sp == SP_W'(STACK_DEPTH));
  assign stack_empty = (sp == '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cmd        = CMD_NONE;
    state_next = state;
    case (state)
      IDLE: begin
        if      (ret)      cmd = CMD_RET;
        else if (call)     cmd = CMD_CALL;
        else if (word_rd)  cmd = CMD_WORD_RD;
        else if (word_wr)  cmd = CMD_WORD_WR;
        else if (ram_enh)  cmd = CMD_ENH;
        else if (ram_enl)  cmd = CMD_ENL;
        else if (ram_load) cmd = CMD_LOAD;
        if (cmd == CMD_WORD_RD) state_next = RD2;
        if (cmd == CMD_WORD_WR) state_next = WR2;
      end
      RD2, WR2: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; later assignments in the block take priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      mar       <= '0;
      mdr       <= '0;
      sp        <= '0;
      stack_err <= 1'b0;
      addr_q    <= '0;
    end else begin
      if (mar_loadh) mar[15:8] <= bus[15:8];
      if (mar_loadl) mar[7:0]  <= bus[7:0];
      if (mdr_load)  mdr[7:0]  <= bus[7:0];
      case (cmd)
        CMD_RET: begin
          if (stack_empty) stack_err <= 1'b1;
          else begin
            mdr <= stack[top_idx];
            sp  <= sp - SP_W'(1);
          end
        end
        CMD_CALL: begin
          if (stack_full) stack_err <= 1'b1;
          else            sp        <= sp + SP_W'(1);
        end
        CMD_WORD_RD: begin
          addr_q    <= ram_idx;
          mdr[15:8] <= ram[ram_idx];
        end
        CMD_WORD_WR: addr_q    <= ram_idx;
        CMD_ENH:     mdr[15:8] <= ram[ram_idx];
        CMD_ENL:     mdr[7:0]  <= ram[ram_idx];
        default: ;
      endcase
      if (state == RD2) mdr[7:0] <= ram[addr_nxt];
    end
  end

  // NOTE: RAM and stack arrays carry no reset; writes are merely suppressed
  // during rst so an aborted word write keeps only its first byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (cmd == CMD_LOAD)    ram[ram_idx]  <= mdr[7:0];
      if (cmd == CMD_WORD_WR) ram[ram_idx]  <= mdr[15:8];
      if (state == WR2)       ram[addr_nxt] <= mdr[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && cmd == CMD_CALL && !stack_full) stack[push_idx] <= bus;
  end

endmodule

// File: tb/tb_stack_memory.sv
// Directed self-checking bench for stack_memory: byte ops, word ops with
// address wrap, return stack overflow/underflow, priority and busy behaviour.
module tb_stack_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        mar_loadh, mar_loadl, mdr_load, ram_load, ram_enh, ram_enl;
  logic        word_rd, word_wr, call, ret;
  logic [15:0] bus;
  logic [15:0] out;
  logic        busy, stack_full, stack_empty, stack_err;

  int n_cmp = 0;
  int n_bad = 0;

  stack_memory #(.ADDR_W(6), .STACK_DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .mar_loadh(mar_loadh), .mar_loadl(mar_loadl), .mdr_load(mdr_load),
    .ram_load(ram_load), .ram_enh(ram_enh), .ram_enl(ram_enl),
    .word_rd(word_rd), .word_wr(word_wr), .call(call), .ret(ret),
    .bus(bus), .out(out), .busy(busy),
    .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic clear_ctrl();
    rst = 1'b0; mar_loadh = 1'b0; mar_loadl = 1'b0; mdr_load = 1'b0;
    ram_load = 1'b0; ram_enh = 1'b0; ram_enl = 1'b0; word_rd = 1'b0;
    word_wr = 1'b0; call = 1'b0; ret = 1'b0; bus = 16'h0000;
  endtask

  // One rising edge, then settle 1 time unit and drop all controls.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_ctrl();
  endtask

  task automatic set_mar(input logic [15:0] v);
    bus = v; mar_loadh = 1'b1; mar_loadl = 1'b1; tick();
  endtask

  task automatic set_mdr_lo(input logic [7:0] v);
    bus = {8'h00, v}; mdr_load = 1'b1; tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick();
    rst = 1'b1; tick();
    n_cmp++; if (out !== 16'h0000) begin n_bad++; $display("FAIL reset_out: got %h want 0000", out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (stack_empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", stack_empty); end
    n_cmp++; if (stack_full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", stack_full); end
    n_cmp++; if (stack_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", stack_err); end
  endtask

  task automatic test_byte_ops();
    set_mar(16'h0005);
    set_mdr_lo(8'hA7);
    ram_load = 1'b1; tick();
    ram_enh = 1'b1; tick();
    n_cmp++; if (out !== 16'hA7A7) begin n_bad++; $display("FAIL byte_enh: got %h want a7a7", out); end
    set_mdr_lo(8'h00);
    n_cmp++; if (out !== 16'hA700) begin n_bad++; $display("FAIL byte_mdr_load: got %h want a700", out); end
    ram_enl = 1'b1; tick();
    n_cmp++; if (out !== 16'hA7A7) begin n_bad++; $display("FAIL byte_enl: got %h want a7a7", out); end
    n_cmp++; if (stack_empty !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL byte_flags: got empty=%b busy=%b want 1/0", stack_empty, busy); end
    // Same-cycle mdr_load loses to ram_enl
    bus = 16'h0055; mdr_load = 1'b1; ram_enl = 1'b1; tick();
    n_cmp++; if (out !== 16'hA7A7) begin n_bad++; $display("FAIL byte_cmd_beats_mdr_load: got %h want a7a7", out); end
  endtask

  task automatic test_word_ops();
    // Seed mdr = 0x1234 through byte ops at addresses 1 and 2
    set_mar(16'h0001); set_mdr_lo(8'h12); ram_load = 1'b1; tick();
    set_mar(16'h0002); set_mdr_lo(8'h34); ram_load = 1'b1; tick();
    set_mar(16'h0001); ram_enh = 1'b1; tick();
    n_cmp++; if (out !== 16'h1234) begin n_bad++; $display("FAIL word_seed: got %h want 1234", out); end
    set_mar(16'h003F);
    word_wr = 1'b1; tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL word_wr_busy1: got %b want 1", busy); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL word_wr_busy2: got %b want 0", busy); end
    // Scramble mdr to 0xA700, then read the two bytes back individually
    set_mar(16'h0005); ram_enh = 1'b1; tick();
    set_mdr_lo(8'h00);
    set_mar(16'h003F); ram_enl = 1'b1; tick();
    n_cmp++; if (out !== 16'hA712) begin n_bad++; $display("FAIL word_wr_hi_byte: got %h want a712", out); end
    set_mar(16'h0000); ram_enl = 1'b1; tick();
    n_cmp++; if (out !== 16'hA734) begin n_bad++; $display("FAIL word_wr_wrap_byte: got %h want a734", out); end
    set_mdr_lo(8'hFF);
    // Upper MAR bits set: index is still 63
    set_mar(16'hFF3F);
    word_rd = 1'b1; tick();
    n_cmp++; if (out !== 16'h12FF) begin n_bad++; $display("FAIL word_rd_edge1: got %h want 12ff", out); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL word_rd_busy1: got %b want 1", busy); end
    bus = 16'h0055; mdr_load = 1'b1; tick();
    n_cmp++; if (out !== 16'h1234) begin n_bad++; $display("FAIL word_rd_edge2: got %h want 1234", out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL word_rd_busy2: got %b want 0", busy); end
  endtask

  task automatic test_stack_fill_drain();
    for (int i = 0; i < 8; i++) begin
      bus = 16'h1000 + 16'(i); call = 1'b1; tick();
    end
    n_cmp++; if (stack_full !== 1'b1 || stack_empty !== 1'b0) begin n_bad++; $display("FAIL stack_full_after8: got full=%b empty=%b want 1/0", stack_full, stack_empty); end
    n_cmp++; if (stack_err !== 1'b0) begin n_bad++; $display("FAIL stack_err_after8: got %b want 0", stack_err); end
    bus = 16'hDEAD; call = 1'b1; tick();
    n_cmp++; if (stack_err !== 1'b1 || stack_full !== 1'b1) begin n_bad++; $display("FAIL stack_overflow: got err=%b full=%b want 1/1", stack_err, stack_full); end
    for (int i = 0; i < 8; i++) begin
      ret = 1'b1; tick();
      n_cmp++; if (out !== 16'h1007 - 16'(i)) begin n_bad++; $display("FAIL stack_pop%0d: got %h want %h", i, out, 16'h1007 - 16'(i)); end
    end
    n_cmp++; if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin n_bad++; $display("FAIL stack_drained: got empty=%b full=%b want 1/0", stack_empty, stack_full); end
    ret = 1'b1; tick();
    n_cmp++; if (out !== 16'h1000 || stack_err !== 1'b1) begin n_bad++; $display("FAIL stack_underflow: got out=%h err=%b want 1000/1", out, stack_err); end
    tick(); tick();
    n_cmp++; if (stack_err !== 1'b1) begin n_bad++; $display("FAIL stack_err_sticky: got %b want 1", stack_err); end
    do_reset();
    n_cmp++; if (stack_err !== 1'b0 || stack_empty !== 1'b1) begin n_bad++; $display("FAIL stack_err_cleared: got err=%b empty=%b want 0/1", stack_err, stack_empty); end
  endtask

  task automatic test_call_ret_same_cycle();
    bus = 16'hBEEF; call = 1'b1; tick();
    n_cmp++; if (stack_empty !== 1'b0) begin n_bad++; $display("FAIL prio_push: got empty=%b want 0", stack_empty); end
    bus = 16'h1111; call = 1'b1; ret = 1'b1; tick();
    n_cmp++; if (out !== 16'hBEEF || stack_empty !== 1'b1) begin n_bad++; $display("FAIL prio_ret_wins: got out=%h empty=%b want beef/1", out, stack_empty); end
    ret = 1'b1; tick();
    n_cmp++; if (out !== 16'hBEEF || stack_err !== 1'b1) begin n_bad++; $display("FAIL prio_no_push: got out=%h err=%b want beef/1", out, stack_err); end
    do_reset();
  endtask

  task automatic test_busy_ignore();
    set_mar(16'h003F);
    word_rd = 1'b1; tick();
    n_cmp++; if (out !== 16'h1200 || busy !== 1'b1) begin n_bad++; $display("FAIL busy_rd_edge1: got out=%h busy=%b want 1200/1", out, busy); end
    bus = 16'h7777; call = 1'b1; tick();
    n_cmp++; if (out !== 16'h1234 || busy !== 1'b0) begin n_bad++; $display("FAIL busy_rd_edge2: got out=%h busy=%b want 1234/0", out, busy); end
    n_cmp++; if (stack_empty !== 1'b1 || stack_err !== 1'b0) begin n_bad++; $display("FAIL busy_call_ignored: got empty=%b err=%b want 1/0", stack_empty, stack_err); end
    word_rd = 1'b1; tick();
    rst = 1'b1; tick();
    n_cmp++; if (out !== 16'h0000 || busy !== 1'b0) begin n_bad++; $display("FAIL rd2_reset: got out=%h busy=%b want 0000/0", out, busy); end
    // mar is 0 after reset; ram[0] holds 0x34 from the wrapped word write
    ram_enl = 1'b1; tick();
    n_cmp++; if (out !== 16'h0034 || busy !== 1'b0) begin n_bad++; $display("FAIL rd2_reset_idle: got out=%h busy=%b want 0034/0", out, busy); end
  endtask

  task automatic test_back_to_back();
    bus = 16'hCAFE; call = 1'b1; tick();
    ret = 1'b1; tick();
    n_cmp++; if (out !== 16'hCAFE || stack_empty !== 1'b1) begin n_bad++; $display("FAIL b2b_push_pop: got out=%h empty=%b want cafe/1", out, stack_empty); end
  endtask

  initial begin
    clear_ctrl();
    test_reset();
    test_byte_ops();
    test_word_ops();
    test_stack_fill_drain();
    test_call_ret_same_cycle();
    test_busy_ignore();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
